// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS parameter sequencer.
// Used by the sequencer top and its testbench.
package dds_pkg;

    localparam int FREQ_W_DEF = 24;
    localparam int AMP_W_DEF  = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_F = 2'd1,
        RAMP_A = 2'd2
    } state_t;

    localparam logic CMD_FREQ = 1'b0;
    localparam logic CMD_AMP  = 1'b1;

endpackage

// File: rtl/dds_tick_gen.sv
// Update tick source: DDS phase wrap, or a forced tick after a
// stretch of busy cycles with no wrap (covers a stopped accumulator).
module dds_tick_gen #(
    parameter int WRAP_TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    input  logic phase_wrap,
    output logic tick
);

    localparam int CW = (WRAP_TIMEOUT > 1) ? $clog2(WRAP_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(WRAP_TIMEOUT - 1);

    logic [CW-1:0] count;
    logic          timeout;

    assign timeout = active && (count == LAST);
    assign tick    = phase_wrap | timeout;

    // Count busy cycles since the last tick or state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (active) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/dds_param_sequencer.sv
// Glitch-free frequency and click-free amplitude updates for a DDS core.
// Frequency lands on a wrap; amplitude ramps one bounded step per wrap.
module dds_param_sequencer
    import dds_pkg::*;
#(
    parameter int FREQ_W       = FREQ_W_DEF,
    parameter int AMP_W        = AMP_W_DEF,
    parameter int AMP_STEP     = 16,
    parameter int WRAP_TIMEOUT = 65535,
    parameter int AMP_INIT     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_sel,
    input  logic [FREQ_W-1:0] cmd_data,
    input  logic              phase_wrap,
    output logic [FREQ_W-1:0] freq_word,
    output logic [AMP_W-1:0]  amp_mult,
    output logic              busy,
    output logic              update_done
);

    localparam logic [AMP_W:0]   STEP_X = (AMP_W + 1)'(AMP_STEP);
    localparam logic [AMP_W-1:0] STEP_N = AMP_W'(AMP_STEP);

    state_t            state;
    logic [FREQ_W-1:0] target_f;
    logic [AMP_W-1:0]  target_a;
    logic [AMP_W-1:0]  cmd_amp;
    logic              transfer;
    logic              same;
    logic              start;
    logic              tick;

    logic [AMP_W:0]    amp_x;
    logic [AMP_W:0]    tgt_x;
    logic [AMP_W:0]    up;
    logic [AMP_W-1:0]  dn;
    logic [AMP_W-1:0]  amp_next;

    assign cmd_ready = (state == IDLE);
    assign busy      = !cmd_ready;
    assign transfer  = cmd_valid && cmd_ready;
    assign cmd_amp   = cmd_data[AMP_W-1:0];
    assign same      = (cmd_sel == CMD_AMP) ? (cmd_amp == amp_mult)
                                            : (cmd_data == freq_word);
    assign start     = transfer && !same;

    dds_tick_gen #(
        .WRAP_TIMEOUT(WRAP_TIMEOUT)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start),
        .active    (busy),
        .phase_wrap(phase_wrap),
        .tick      (tick)
    );

    // Next ramp value, one extra bit so the step cannot wrap past the rails.
    always_comb begin
        amp_x = {1'b0, amp_mult};
        tgt_x = {1'b0, target_a};
        up    = amp_x + STEP_X;
        dn    = amp_mult - STEP_N;
        if (amp_x < tgt_x) begin
            amp_next = (up > tgt_x) ? target_a : up[AMP_W-1:0];
        end else begin
            amp_next = (amp_x < tgt_x + STEP_X) ? target_a : dn;
        end
    end

    // Command FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            freq_word   <= '0;
            amp_mult    <= AMP_W'(AMP_INIT);
            update_done <= 1'b0;
            target_f    <= '0;
            target_a    <= '0;
        end else begin
            update_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (transfer) begin
                        if (cmd_sel == CMD_AMP) begin
                            target_a <= cmd_amp;
                        end else begin
                            target_f <= cmd_data;
                        end
                        if (same) begin
                            update_done <= 1'b1;
                        end else if (cmd_sel == CMD_AMP) begin
                            state <= RAMP_A;
                        end else begin
                            state <= WAIT_F;
                        end
                    end
                end
                WAIT_F: begin
                    if (tick) begin
                        freq_word   <= target_f;
                        update_done <= 1'b1;
                        state       <= IDLE;
                    end
                end
                RAMP_A: begin
                    if (tick) begin
                        amp_mult <= amp_next;
                        if (amp_next == target_a) begin
                            update_done <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_param_sequencer.sv
// Scoreboard bench for dds_param_sequencer: directed scenarios,
// then randomized commands against a queue-based reference model.
module tb_dds_param_sequencer;
    import dds_pkg::*;

    localparam int FW   = 24;
    localparam int AW   = 12;
    localparam int STEP = 16;
    localparam int TO   = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_sel = 1'b0;
    logic [FW-1:0] cmd_data = '0;
    logic          phase_wrap = 1'b0;
    logic [FW-1:0] freq_word;
    logic [AW-1:0] amp_mult;
    logic          busy;
    logic          update_done;

    dds_param_sequencer #(
        .FREQ_W      (FW),
        .AMP_W       (AW),
        .AMP_STEP    (STEP),
        .WRAP_TIMEOUT(TO),
        .AMP_INIT    (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_data   (cmd_data),
        .phase_wrap (phase_wrap),
        .freq_word  (freq_word),
        .amp_mult   (amp_mult),
        .busy       (busy),
        .update_done(update_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [FW-1:0] fq[$];
    logic [AW-1:0] aq[$];
    logic [63:0]   dq[$];

    logic [FW-1:0] m_freq = '0;
    logic [AW-1:0] m_amp = '0;
    logic [FW-1:0] prev_f = '0;
    logic [AW-1:0] prev_a = '0;
    bit            mon_en = 1'b0;
    bit            chk_wrap = 1'b0;
    bit            rnd_on = 1'b0;
    logic          wrap_q = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: expected freq change, amp trajectory and completion.
    task automatic push_cmd(input logic sel, input logic [FW-1:0] data);
        int a;
        int t;
        if (sel == CMD_FREQ) begin
            if (data != m_freq) fq.push_back(data);
            m_freq = data;
        end else begin
            a = int'(m_amp);
            t = int'(data[AW-1:0]);
            while (a != t) begin
                if (a < t) a = (a + STEP > t) ? t : a + STEP;
                else       a = (a - STEP < t) ? t : a - STEP;
                aq.push_back(AW'(a));
            end
            m_amp = AW'(t);
        end
        dq.push_back({28'd0, m_freq, m_amp});
    endtask

    task automatic send_cmd(input logic sel, input logic [FW-1:0] data);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("ready_wait", 64'(cmd_ready), 64'd1);
            return;
        end
        cmd_sel   = sel;
        cmd_data  = data;
        cmd_valid = 1'b1;
        push_cmd(sel, data);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wrap();
        @(negedge clk);
        phase_wrap = 1'b1;
        @(negedge clk);
        phase_wrap = 1'b0;
    endtask

    always @(posedge clk) wrap_q <= phase_wrap;

    // Monitor: pop expectations whenever the DUT presents a change.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (freq_word != prev_f) begin
                if (fq.size() == 0) check("freq_unexp", 64'(freq_word), 64'(prev_f));
                else check("freq_val", 64'(freq_word), 64'(fq.pop_front()));
            end
            if (amp_mult != prev_a) begin
                if (aq.size() == 0) check("amp_unexp", 64'(amp_mult), 64'(prev_a));
                else check("amp_step", 64'(amp_mult), 64'(aq.pop_front()));
            end
            if (chk_wrap && (freq_word != prev_f || amp_mult != prev_a))
                check("chg_on_wrap", 64'(wrap_q), 64'd1);
            if (update_done) begin
                if (dq.size() == 0) check("done_unexp", 64'd1, 64'd0);
                else check("done_val", {28'd0, freq_word, amp_mult}, dq.pop_front());
            end
            check("busy_ready", 64'(busy), 64'(!cmd_ready));
            prev_f = freq_word;
            prev_a = amp_mult;
        end
    end

    // Random phase_wrap source for the randomized phase.
    initial begin
        wait (rnd_on);
        while (rnd_on) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            phase_wrap = 1'b1;
            @(negedge clk);
            phase_wrap = 1'b0;
        end
    end

    initial begin
        int n;
        int d;
        int t;
        logic [FW-1:0] data;
        logic [AW-1:0] exp_a[4];

        repeat (3) @(negedge clk);
        check("rst_freq", 64'(freq_word), 64'd0);
        check("rst_amp", 64'(amp_mult), 64'd0);
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(update_done), 64'd0);
        rst_n  = 1'b1;
        prev_f = freq_word;
        prev_a = amp_mult;
        mon_en = 1'b1;

        send_cmd(CMD_FREQ, 24'h012345);
        check("f_busy", 64'(busy), 64'd1);
        check("f_ready", 64'(cmd_ready), 64'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("f_hold", 64'(freq_word), 64'd0);
        end
        wrap();
        check("f_new", 64'(freq_word), 64'h012345);
        check("f_done", 64'(update_done), 64'd1);
        @(negedge clk);
        check("f_done_pulse", 64'(update_done), 64'd0);
        check("f_ready_back", 64'(cmd_ready), 64'd1);

        @(negedge clk);
        cmd_sel = CMD_FREQ;
        cmd_data = 24'h0ABCDE;
        cmd_valid = 1'b1;
        phase_wrap = 1'b1;
        push_cmd(CMD_FREQ, 24'h0ABCDE);
        @(negedge clk);
        cmd_valid = 1'b0;
        phase_wrap = 1'b0;
        check("f_same_wrap", 64'(freq_word), 64'h012345);
        check("f_same_busy", 64'(busy), 64'd1);
        wrap();
        check("f_new2", 64'(freq_word), 64'h0ABCDE);

        send_cmd(CMD_AMP, 24'hABC040);
        for (int k = 0; k < 4; k++) begin
            repeat (7) @(negedge clk);
            wrap();
            check("a_up", 64'(amp_mult), 64'(16 * (k + 1)));
            check("a_up_done", 64'(update_done), 64'(k == 3));
        end

        exp_a = '{12'h030, 12'h020, 12'h010, 12'h005};
        send_cmd(CMD_AMP, 24'h000005);
        for (int k = 0; k < 4; k++) begin
            repeat (7) @(negedge clk);
            wrap();
            check("a_dn", 64'(amp_mult), 64'(exp_a[k]));
        end
        check("a_dn_done", 64'(update_done), 64'd1);

        send_cmd(CMD_AMP, 24'hFFF005);
        check("eq_done", 64'(update_done), 64'd1);
        check("eq_busy", 64'(busy), 64'd0);

        send_cmd(CMD_FREQ, 24'h0FEDCB);
        n = 0;
        while (freq_word == 24'h0ABCDE && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(TO));

        send_cmd(CMD_AMP, 24'h000805);
        @(negedge clk);
        cmd_sel = CMD_FREQ;
        cmd_data = 24'h000777;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(negedge clk);
            check("hold_ready", 64'(cmd_ready), 64'd0);
            wrap();
            check("hold_busy", 64'(busy), 64'd1);
        end
        check("hold_amp", 64'(amp_mult), 64'h035);
        @(negedge clk);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_amp", 64'(amp_mult), 64'd0);
        check("rst_mid_freq", 64'(freq_word), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        fq.delete();
        aq.delete();
        dq.delete();
        m_freq = '0;
        m_amp = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_cmd(CMD_FREQ, 24'h000777);
        prev_f = freq_word;
        prev_a = amp_mult;
        mon_en = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_xfer", 64'(busy), 64'd1);
        wrap();
        check("held_freq", 64'(freq_word), 64'h000777);

        chk_wrap = 1'b1;
        rnd_on = 1'b1;
        send_cmd(CMD_AMP, 24'h000FFF);
        send_cmd(CMD_AMP, 24'h000FF9);
        send_cmd(CMD_AMP, 24'h000FFF);
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 1) == 0) begin
                data = ($urandom_range(0, 3) == 0) ? m_freq : FW'($urandom);
                send_cmd(CMD_FREQ, data);
            end else begin
                d = $urandom_range(0, 300);
                t = int'(m_amp);
                if ($urandom_range(0, 3) == 0) d = 0;
                if ($urandom_range(0, 1) == 0) t = (t + d > 4095) ? 4095 : t + d;
                else t = (t - d < 0) ? 0 : t - d;
                data = {AW'($urandom), AW'(t)};
                send_cmd(CMD_AMP, data);
            end
        end

        n = 0;
        while (dq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 64'(dq.size()), 64'd0);
        check("drain_amp", 64'(aq.size()), 64'd0);
        check("drain_freq", 64'(fq.size()), 64'd0);
        rnd_on = 1'b0;
        mon_en = 1'b0;
        repeat (8) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
